// File: rtl/dcache_ctrl_nway_if.sv
// Bus bundle between the MEM stage / memory and dcache_ctrl_nway.
//   cpu_*  : pipeline-side access port (request, store data, load data, stall)
//   mem_*  : req/ack memory port (line reads, word writes)
// master = the environment (pipeline + memory), slave = the cache controller.
interface dcache_ctrl_nway_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl_nway.sv
// dcache_ctrl_nway: N-set, 1/2-way, write-through, no-write-allocate data
// cache controller for the MEM stage. Misses refill a whole line over the
// req/ack memory port; every store is written through as a single word.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   bus (slave)          cpu_* access port and mem_* memory port
//   hit_cnt_o/miss_cnt_o performance counters (only with PERF_CNT_EN)
// Optional feature macro: PERF_CNT_EN
//
//   state  | meaning
//   IDLE   | combinational lookup; hits complete with no stall
//   REFILL | line read outstanding, install into victim way on mem_ack
//   WRITE  | word write-through outstanding, completes on mem_ack
module dcache_ctrl_nway #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 16,
  parameter int WAYS           = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_ctrl_nway_if.slave  bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("dcache_ctrl_nway: WAYS must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]   data_q  [WAYS][SETS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [SETS-1:0]     lru_q;      // way to evict next when the set is full
  logic [ADDR_W-1:2]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                victim_q;
  logic                done_q;     // current access already went to memory

  logic [IDX_W-1:0]    idx, aidx;
  logic [TAG_W-1:0]    tag, atag;
  logic [WOFF_W-1:0]   woff;
  logic                hit, hit_w, victim, stall;
  logic [LINE_W-1:0]   hit_line;
  logic                unused_addr_bits;

  assign idx  = bus.cpu_addr[OFF_W +: IDX_W];
  assign tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign woff = bus.cpu_addr[2 +: WOFF_W];
  assign aidx = addr_q[OFF_W +: IDX_W];
  assign atag = addr_q[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  // Lookup only counts as a hit while the FSM is free to serve the pipeline.
  always_comb begin
    hit   = 1'b0;
    hit_w = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit   = bus.cpu_req && (state_q == IDLE);
        hit_w = w[0];
      end
    end
    victim = lru_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = w[0];
    end
    if (WAYS == 1) victim = 1'b0;
    hit_line = data_q[hit_w][idx];
  end

  assign bus.cpu_rdata = hit ? hit_line[woff*DATA_W +: DATA_W] : '0;
  assign bus.cpu_stall = stall;

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            // A store that already completed its write-through must not repeat it.
            if (!done_q) begin
              stall   = 1'b1;
              state_d = WRITE;
            end
          end else if (!hit) begin
            stall   = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall        = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (bus.mem_ack) state_d = IDLE;
      end
      WRITE: begin
        stall         = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {addr_q, 2'b00};
        bus.mem_wdata = wdata_q;
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '{default: '0};
      lru_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) done_q <= 1'b1;
      else if (state_q == IDLE && !stall)     done_q <= 1'b0;
      if (WAYS == 2 && hit && !(bus.cpu_we && done_q)) lru_q[idx] <= ~hit_w;
      if (state_q == REFILL && bus.mem_ack) begin
        valid_q[aidx][victim_q] <= 1'b1;
        if (WAYS == 2) lru_q[aidx] <= ~victim_q;
      end
    end
  end

  // Arrays and transaction registers carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && state_d != IDLE) begin
      addr_q   <= bus.cpu_addr[ADDR_W-1:2];
      wdata_q  <= bus.cpu_wdata;
      victim_q <= victim;
    end
    if (state_q == REFILL && bus.mem_ack) begin
      data_q[victim_q][aidx] <= bus.mem_rdata;
      tag_q[victim_q][aidx]  <= atag;
    end else if (hit && bus.cpu_we && !done_q) begin
      data_q[hit_w][idx][woff*DATA_W +: DATA_W] <= bus.cpu_wdata;
    end
  end

`ifdef PERF_CNT_EN
  // Re-lookups after a refill and repeated store cycles are not new hits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && !done_q)                     hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (state_q == IDLE && state_d != IDLE) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Directed bench for dcache_ctrl_nway (SETS=16, WORDS_PER_LINE=4, WAYS=2).
// The memory responder acks on the 3rd cycle of mem_req and returns line words
// of the form {16'h5A5A, word address[15:0]}.
module tb_dcache_ctrl_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dcache_ctrl_nway_if #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(4)) bus ();

`ifdef PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl_nway #(
    .ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(4), .SETS(16), .WAYS(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = {16'h5A5A, a[15:0] + 16'(4*i)};
    return l;
  endfunction

  // Called at a negedge; presents one access and plays memory until it completes.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls, output int nreq, output logic [31:0] maddr,
                        output logic mwe, output logic [31:0] mwd, output logic [31:0] rdata);
    int run;
    bit fin;
    stalls = 0; nreq = 0; run = 0; fin = 0;
    maddr = '0; mwe = 1'b0; mwd = '0; rdata = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    for (int c = 0; c < 40 && !fin; c++) begin
      #1;
      if (bus.mem_req) begin
        if (run == 0) begin
          nreq++;
          maddr = bus.mem_addr; mwe = bus.mem_we; mwd = bus.mem_wdata;
        end
        run++;
        bus.mem_rdata = line_of(bus.mem_addr);
        bus.mem_ack   = (run == 3);
      end else begin
        run = 0;
        bus.mem_ack = 1'b0;
      end
      if (bus.cpu_stall) stalls++;
      else begin
        rdata = bus.cpu_rdata;
        fin   = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
    bus.cpu_req = 1'b0;
    check("access_completes", 32'(fin), 32'd1);
  endtask

  int          st, nr;
  logic [31:0] ma, mw, rd;
  logic        mwe_o;
`ifdef PERF_CNT_EN
  logic [31:0] h0, m0;
`endif

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_stall",   32'(bus.cpu_stall), 32'd0);
    check("rst_rdata",   bus.cpu_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: cold load miss
    access(1'b0, 32'h040, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t1_stall", 32'(st), 32'd4);
    check("t1_nreq",  32'(nr), 32'd1);
    check("t1_maddr", ma, 32'h040);
    check("t1_mwe",   32'(mwe_o), 32'd0);
    check("t1_rdata", rd, 32'h5A5A_0040);

    // 2: hit on the refilled line
    access(1'b0, 32'h044, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t2_stall", 32'(st), 32'd0);
    check("t2_nreq",  32'(nr), 32'd0);
    check("t2_rdata", rd, 32'h5A5A_0044);

    // 3: store hit writes through, then reads back from the cache
    access(1'b1, 32'h048, 32'hDEAD_BEEF, st, nr, ma, mwe_o, mw, rd);
    check("t3_stall", 32'(st), 32'd4);
    check("t3_nreq",  32'(nr), 32'd1);
    check("t3_mwe",   32'(mwe_o), 32'd1);
    check("t3_maddr", ma, 32'h048);
    check("t3_mwdata", mw, 32'hDEAD_BEEF);
    access(1'b0, 32'h048, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t3_ld_stall", 32'(st), 32'd0);
    check("t3_ld_nreq",  32'(nr), 32'd0);
    check("t3_ld_rdata", rd, 32'hDEAD_BEEF);

    // 4: LRU replacement in set 4
    access(1'b0, 32'h440, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t4_fill440_stall", 32'(st), 32'd4);
    access(1'b0, 32'h040, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t4_hit040_stall", 32'(st), 32'd0);
    access(1'b0, 32'h840, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t4_fill840_stall", 32'(st), 32'd4);
    check("t4_fill840_rdata", rd, 32'h5A5A_0840);
    access(1'b0, 32'h040, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t4_rehit040_stall", 32'(st), 32'd0);
    check("t4_rehit040_rdata", rd, 32'h5A5A_0040);
    access(1'b0, 32'h440, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t4_miss440_stall", 32'(st), 32'd4);
    check("t4_miss440_nreq",  32'(nr), 32'd1);
    check("t4_miss440_rdata", rd, 32'h5A5A_0440);

    // 5: reset during REFILL, late ack ignored
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hC40;
    #1;
    check("t5_idle_stall", 32'(bus.cpu_stall), 32'd1);
    @(posedge clk); @(negedge clk);
    check("t5_refill_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1; bus.cpu_req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("t5_post_rst_req",   32'(bus.mem_req), 32'd0);
    check("t5_post_rst_stall", 32'(bus.cpu_stall), 32'd0);
    bus.mem_rdata = line_of(32'hC40);
    bus.mem_ack   = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_ack = 1'b0;
    check("t5_late_ack_req", 32'(bus.mem_req), 32'd0);
    access(1'b0, 32'hC40, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t5_c40_stall", 32'(st), 32'd4);
    access(1'b0, 32'h040, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t5_040_stall", 32'(st), 32'd4);
    check("t5_040_nreq",  32'(nr), 32'd1);

    // 6: store miss does not allocate
`ifdef PERF_CNT_EN
    h0 = hit_cnt; m0 = miss_cnt;
`endif
    access(1'b1, 32'h100, 32'h1234_5678, st, nr, ma, mwe_o, mw, rd);
    check("t6_st_stall", 32'(st), 32'd4);
    check("t6_st_mwe",   32'(mwe_o), 32'd1);
    access(1'b0, 32'h100, 32'h0, st, nr, ma, mwe_o, mw, rd);
    check("t6_ld_stall", 32'(st), 32'd4);
    check("t6_ld_mwe",   32'(mwe_o), 32'd0);
    check("t6_ld_maddr", ma, 32'h100);
    check("t6_ld_rdata", rd, 32'h5A5A_0100);
`ifdef PERF_CNT_EN
    check("t6_miss_cnt", miss_cnt - m0, 32'd2);
    check("t6_hit_cnt",  hit_cnt - h0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
